fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Parametrised successor of the pipeline's fetch/PC-next logic. Owns the IF program counter and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Arbitrates PC redirects: exception vectors, EX-stage mispredict recovery, ID-stage jump/jr, BTB prediction and sequential fetch.
- Emits prediction metadata to travel down the pipe and a mispredict/flush pulse to the hazard logic.

Parameters:
- ADDR_W, 32, PC width; bit ADDR_W-1 is the supervisor bit.
- BTB_DEPTH, 16, BTB entries; power of 2, minimum 2.
- RESET_PC, 32'h8000_0000, PC value on reset.
- ILLOP_PC, 32'h8000_0004, illegal-opcode vector.
- XADR_PC, 32'h8000_0008, interrupt vector.

Ports:
- sysclk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_write  in  1  fetch enable; 0 = stall.
- irq_take  in  1  take interrupt vector.
- illop_take  in  1  take illegal-opcode vector.
- id_jump  in  1  ID-stage j/jal/jr/jalr resolved.
- id_jump_target  in  ADDR_W  jump target (jr value already forwarded).
- ex_br_valid  in  1  conditional branch resolved in EX this cycle.
- ex_br_pc  in  ADDR_W  PC of that branch.
- ex_br_taken  in  1  actual outcome.
- ex_br_target  in  ADDR_W  actual taken target.
- ex_pred_taken  in  1  prediction carried with the branch.
- ex_pred_target  in  ADDR_W  predicted target carried with the branch.
- if_pc  out  ADDR_W  current fetch PC.
- if_pc_plus_4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W.
- if_pred_taken  out  1  BTB predicts taken for if_pc.
- if_pred_target  out  ADDR_W  BTB target for if_pc.
- mispredict  out  1  combinational; flush IF/ID and ID/EX this cycle.

Behaviour:
- Reset (async, active-high): if_pc = RESET_PC. All BTB valid bits = 0, so if_pred_taken = 0 and mispredict = 0 while ex_br_valid = 0.
- BTB geometry: IDX_W = log2(BTB_DEPTH); index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2], with the supervisor bit included in the tag.
- Each entry holds {valid, tag, target, ctr[1:0]}.
- Lookup (combinational on if_pc): hit = valid && tag match. if_pred_taken = hit && ctr[1]. if_pred_target = entry target on hit, else if_pc_plus_4.
- mispredict = ex_br_valid && ((ex_pred_taken != ex_br_taken) || (ex_br_taken && ex_pred_target != ex_br_target)).
- Recovery target = ex_br_taken ? ex_br_target : ex_br_pc + 4.
- Next-PC priority, highest first; PC updates on the rising edge:
  1. illop_take -> ILLOP_PC.
  2. irq_take -> XADR_PC.
  3. mispredict -> recovery target.
  4. id_jump -> id_jump_target.
  5. if_pred_taken -> if_pred_target.
  6. else -> if_pc_plus_4.
- Priorities 1-3 update the PC even when pc_write = 0; they kill the stalled instruction. Priorities 4-6 update only when pc_write = 1.
- BTB update (sync, on ex_br_valid only; independent of pc_write):
  - Hit at ex_br_pc: counter saturating increment if taken, decrement if not (0..3). Target overwritten with ex_br_target when taken.
  - Miss and taken: allocate/replace, valid = 1, tag, target = ex_br_target, ctr = 2'b10.
  - Miss and not taken: no change.
- Lookup and update on the same index in the same cycle: lookup returns the pre-update contents (no bypass).
- Exceptions do not block a same-cycle BTB update.
- PC arithmetic wraps modulo 2^ADDR_W. The unit imposes no supervisor-bit masking: targets are used verbatim, and callers supply a composed target.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately.

Optional Feature:
- Macro: FETCH_PC_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32): count of ex_br_valid cycles.
  - stat_mispred (32): count of mispredict cycles.
- Both counters saturate at 2^32-1 and reset to 0.
- When undefined, both ports exist, are driven constant 0, and no counters are built.

Decomposition:
- Shared package fetch_pkg holds:
  - Next-PC source encodings (NPC_SEQ, NPC_PRED, NPC_JUMP, NPC_RECOVER, NPC_ILLOP, NPC_XADR).
  - Default vector constants.
  - The 2-bit counter encodings (STRONG_NT = 0 .. STRONG_T = 3).
- Sub-module btb_table: storage array, async-clear valid bits, combinational read, synchronous write, parametrised by ADDR_W and BTB_DEPTH.

Test Plan:
- Reset: release reset -> if_pc = 0x8000_0000; then 3 edges with pc_write = 1 -> 0x8000_0004, 0x8000_0008, 0x8000_000C; if_pred_taken = 0 throughout.
- Cold taken branch at 0x8000_0010 -> 0x8000_0040: ex_br_valid = 1, ex_pred_taken = 0, ex_br_taken = 1 -> mispredict = 1 and next if_pc = 0x8000_0040. A later fetch at 0x8000_0010 gives if_pred_taken = 1, target 0x8000_0040.
- Counter hysteresis: train one branch taken twice (ctr = 3), then not-taken once -> still predicts taken (ctr = 2); a second not-taken -> predicts not-taken. The not-taken recovery target is ex_br_pc + 4.
- Stall interaction: pc_write = 0 with id_jump = 1 -> PC holds. pc_write = 0 with mispredict -> PC = recovery target. illop_take and mispredict together -> PC = 0x8000_0004.
- Aliasing with BTB_DEPTH = 4: branches at 0x8000_0000 and 0x8000_0010 share index 0. The second allocation replaces the first; fetching 0x8000_0000 then misses (tag mismatch).
- FETCH_PC_STATS_EN: 10 resolved branches with 3 mispredicts -> stat_branches = 10, stat_mispred = 3; reset mid-run clears both to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch/PC-next unit: next-PC sources, default vectors,
// and the 2-bit branch counter states with their saturating update.
package fetch_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_PRED,
        NPC_JUMP,
        NPC_RECOVER,
        NPC_ILLOP,
        NPC_XADR
    } npc_sel_e;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_PC  = 32'h8000_0008;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == STRONG_T) ? ctr : ctr + 2'd1;
        return (ctr == STRONG_NT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// EX-side update lookup), one synchronous write port, async-cleared valid bits.
module btb_table #(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16,
    parameter int IDX_W     = $clog2(BTB_DEPTH),
    parameter int TAG_W     = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  a_idx,
    output logic              a_valid,
    output logic [TAG_W-1:0]  a_tag,
    output logic [ADDR_W-1:0] a_target,
    output logic [1:0]        a_ctr,
    input  logic [IDX_W-1:0]  b_idx,
    output logic              b_valid,
    output logic [TAG_W-1:0]  b_tag,
    output logic [ADDR_W-1:0] b_target,
    output logic [1:0]        b_ctr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic [1:0]        wr_ctr
);

    logic [BTB_DEPTH-1:0] valid;
    logic [TAG_W-1:0]     tags    [BTB_DEPTH];
    logic [ADDR_W-1:0]    targets [BTB_DEPTH];
    logic [1:0]           ctrs    [BTB_DEPTH];

    // Only valid bits need clearing; payload is ignored until valid is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
            ctrs[wr_idx]    <= wr_ctr;
        end
    end

    assign a_valid  = valid[a_idx];
    assign a_tag    = tags[a_idx];
    assign a_target = targets[a_idx];
    assign a_ctr    = ctrs[a_idx];

    assign b_valid  = valid[b_idx];
    assign b_tag    = tags[b_idx];
    assign b_target = targets[b_idx];
    assign b_ctr    = ctrs[b_idx];

endmodule

// File: rtl/fetch_pc_unit.sv
// IF program counter, BTB prediction and next-PC redirect arbitration.
// Optional FETCH_PC_STATS_EN builds saturating branch/mispredict counters.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] ILLOP_PC  = ADDR_W'(DEF_ILLOP_PC),
    parameter logic [ADDR_W-1:0] XADR_PC   = ADDR_W'(DEF_XADR_PC)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic              irq_take,
    input  logic              illop_take,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              ex_br_valid,
    input  logic [ADDR_W-1:0] ex_br_pc,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus_4,
    output logic              if_pred_taken,
    output logic [ADDR_W-1:0] if_pred_target,
    output logic              mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int                IDX_W = $clog2(BTB_DEPTH);
    localparam int                TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_q, pc_d, recover_pc;
    logic              pc_en;
    npc_sel_e          sel;

    logic              if_valid, ex_valid, if_hit, ex_hit;
    logic [TAG_W-1:0]  if_tag_rd, ex_tag_rd;
    logic [ADDR_W-1:0] if_target_rd, ex_target_rd;
    logic [1:0]        if_ctr_rd, ex_ctr_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_target;
    logic [1:0]        wr_ctr;

    btb_table #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_btb (
        .clk       (sysclk),
        .rst       (reset),
        .a_idx     (pc_q[IDX_W+1:2]),
        .a_valid   (if_valid),
        .a_tag     (if_tag_rd),
        .a_target  (if_target_rd),
        .a_ctr     (if_ctr_rd),
        .b_idx     (ex_br_pc[IDX_W+1:2]),
        .b_valid   (ex_valid),
        .b_tag     (ex_tag_rd),
        .b_target  (ex_target_rd),
        .b_ctr     (ex_ctr_rd),
        .wr_en     (wr_en),
        .wr_idx    (ex_br_pc[IDX_W+1:2]),
        .wr_tag    (ex_br_pc[ADDR_W-1:IDX_W+2]),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr)
    );

    assign if_pc          = pc_q;
    assign if_pc_plus_4   = pc_q + STEP;
    assign if_hit         = if_valid && (if_tag_rd == pc_q[ADDR_W-1:IDX_W+2]);
    assign if_pred_taken  = if_hit && if_ctr_rd[1];
    assign if_pred_target = if_hit ? if_target_rd : if_pc_plus_4;

    assign mispredict = ex_br_valid && ((ex_pred_taken != ex_br_taken) ||
                        (ex_br_taken && (ex_pred_target != ex_br_target)));
    assign recover_pc = ex_br_taken ? ex_br_target : ex_br_pc + STEP;

    // Not-taken misses leave the table alone; a not-taken hit keeps its target.
    assign ex_hit    = ex_valid && (ex_tag_rd == ex_br_pc[ADDR_W-1:IDX_W+2]);
    assign wr_en     = ex_br_valid && (ex_hit || ex_br_taken);
    assign wr_target = ex_br_taken ? ex_br_target : ex_target_rd;
    assign wr_ctr    = ex_hit ? ctr_next(ex_ctr_rd, ex_br_taken) : 2'(WEAK_T);

    // Exceptions and recovery kill the stalled instruction, so they ignore pc_write.
    always_comb begin
        sel   = NPC_SEQ;
        pc_en = pc_write;
        if (illop_take) begin
            sel   = NPC_ILLOP;
            pc_en = 1'b1;
        end else if (irq_take) begin
            sel   = NPC_XADR;
            pc_en = 1'b1;
        end else if (mispredict) begin
            sel   = NPC_RECOVER;
            pc_en = 1'b1;
        end else if (id_jump) begin
            sel   = NPC_JUMP;
        end else if (if_pred_taken) begin
            sel   = NPC_PRED;
        end
    end

    always_comb begin
        pc_d = if_pc_plus_4;
        case (sel)
            NPC_ILLOP:   pc_d = ILLOP_PC;
            NPC_XADR:    pc_d = XADR_PC;
            NPC_RECOVER: pc_d = recover_pc;
            NPC_JUMP:    pc_d = id_jump_target;
            NPC_PRED:    pc_d = if_pred_target;
            default:     pc_d = if_pc_plus_4;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC;
        else if (pc_en)
            pc_q <= pc_d;
    end

`ifdef FETCH_PC_STATS_EN
    logic [31:0] br_cnt, mp_cnt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            if (ex_br_valid && br_cnt != '1)
                br_cnt <= br_cnt + 32'd1;
            if (mispredict && mp_cnt != '1)
                mp_cnt <= mp_cnt + 32'd1;
        end
    end

    assign stat_branches = br_cnt;
    assign stat_mispred  = mp_cnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit (BTB_DEPTH = 4) with a BTB/PC reference model;
// next-PC expectations travel through a scoreboard queue across each clock edge.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_V   = 32'h8000_0000;
    localparam logic [31:0] ILLOP_V = 32'h8000_0004;
    localparam logic [31:0] XADR_V  = 32'h8000_0008;
`ifdef FETCH_PC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        sysclk, reset;
    logic        pc_write, irq_take, illop_take, id_jump;
    logic [31:0] id_jump_target;
    logic        ex_br_valid, ex_br_taken, ex_pred_taken;
    logic [31:0] ex_br_pc, ex_br_target, ex_pred_target;
    logic [31:0] if_pc, if_pc_plus_4, if_pred_target;
    logic        if_pred_taken, mispredict;
    logic [31:0] stat_branches, stat_mispred;

    fetch_pc_unit #(.ADDR_W(32), .BTB_DEPTH(4)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .pc_write       (pc_write),
        .irq_take       (irq_take),
        .illop_take     (illop_take),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .ex_br_valid    (ex_br_valid),
        .ex_br_pc       (ex_br_pc),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .mispredict     (mispredict),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    // Reference model: 4-entry BTB, index pc[3:2], tag pc[31:4].
    logic [31:0] m_pc;
    logic        mv   [4];
    logic [27:0] mtag [4];
    logic [31:0] mtgt [4];
    logic [1:0]  mctr [4];
    int          mb, mm;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic clr();
        pc_write = 1'b1; irq_take = 1'b0; illop_take = 1'b0;
        id_jump = 1'b0; id_jump_target = '0;
        ex_br_valid = 1'b0; ex_br_pc = '0; ex_br_taken = 1'b0; ex_br_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        chk({tag, ".pc"}, if_pc, RST_V);
        chk({tag, ".pred"}, {31'd0, if_pred_taken}, 32'd0);
        chk({tag, ".mp"}, {31'd0, mispredict}, 32'd0);
        chk({tag, ".sbr"}, stat_branches, 32'd0);
        chk({tag, ".smp"}, stat_mispred, 32'd0);
        reset = 1'b0;
        m_pc = RST_V;
        for (int k = 0; k < 4; k++) mv[k] = 1'b0;
        mb = 0; mm = 0;
        exp_q.delete();
    endtask

    task automatic step(input string tag);
        int          i, j;
        logic        hit, pt, mp, jhit;
        logic [31:0] etgt, rec, nx;
        #1;
        i    = int'(m_pc[3:2]);
        hit  = mv[i] && (mtag[i] == m_pc[31:4]);
        pt   = hit && mctr[i][1];
        etgt = hit ? mtgt[i] : m_pc + 32'd4;
        mp   = ex_br_valid && ((ex_pred_taken != ex_br_taken) ||
               (ex_br_taken && ex_pred_target != ex_br_target));
        rec  = ex_br_taken ? ex_br_target : ex_br_pc + 32'd4;
        chk({tag, ".p4"}, if_pc_plus_4, m_pc + 32'd4);
        chk({tag, ".pred"}, {31'd0, if_pred_taken}, {31'd0, pt});
        chk({tag, ".ptgt"}, if_pred_target, etgt);
        chk({tag, ".mp"}, {31'd0, mispredict}, {31'd0, mp});

        if (illop_take)      nx = ILLOP_V;
        else if (irq_take)   nx = XADR_V;
        else if (mp)         nx = rec;
        else if (!pc_write)  nx = m_pc;
        else if (id_jump)    nx = id_jump_target;
        else if (pt)         nx = etgt;
        else                 nx = m_pc + 32'd4;
        exp_q.push_back(nx);

        if (ex_br_valid) begin
            j    = int'(ex_br_pc[3:2]);
            jhit = mv[j] && (mtag[j] == ex_br_pc[31:4]);
            if (jhit) begin
                if (ex_br_taken) begin
                    if (mctr[j] != 2'd3) mctr[j] = mctr[j] + 2'd1;
                    mtgt[j] = ex_br_target;
                end else if (mctr[j] != 2'd0) begin
                    mctr[j] = mctr[j] - 2'd1;
                end
            end else if (ex_br_taken) begin
                mv[j] = 1'b1; mtag[j] = ex_br_pc[31:4];
                mtgt[j] = ex_br_target; mctr[j] = 2'd2;
            end
            mb++;
        end
        if (mp) mm++;

        @(posedge sysclk);
        #1;
        m_pc = exp_q.pop_front();
        chk({tag, ".pc"}, if_pc, m_pc);
    endtask

    task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
        ex_br_valid = 1'b1; ex_br_pc = pc; ex_br_taken = tk; ex_br_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic jmp(input logic [31:0] tgt);
        id_jump = 1'b1; id_jump_target = tgt;
    endtask

    initial begin
        clr();
        reset = 1'b0;
        #1;
        do_reset("rst");

        step("seq1"); step("seq2"); step("seq3");

        clr(); br(32'h8000_0010, 1, 32'h8000_0040, 0, 32'h0); step("cold");
        clr(); jmp(32'h8000_0010); step("j10a");
        clr(); step("pred10");

        // Hysteresis: ctr 2 -> 3 -> 2 (still taken) -> 1 (not taken)
        clr(); br(32'h8000_0010, 1, 32'h8000_0040, 1, 32'h8000_0040); step("tk2");
        clr(); br(32'h8000_0010, 0, 32'h8000_0040, 1, 32'h8000_0040); step("nt1");
        clr(); jmp(32'h8000_0010); step("j10b");
        clr(); step("hyst_t");
        clr(); br(32'h8000_0010, 0, 32'h8000_0040, 1, 32'h8000_0040); step("nt2");
        clr(); jmp(32'h8000_0010); step("j10c");
        clr(); step("hyst_nt");
        clr(); br(32'h8000_0010, 1, 32'h8000_0040, 1, 32'h8000_0080); step("badtgt");

        // Stall interaction and exception priority
        clr(); pc_write = 0; jmp(32'h8000_0100); step("stall_jmp");
        clr(); pc_write = 0; step("stall_hold");
        clr(); pc_write = 0; br(32'h8000_0030, 0, 32'h8000_0050, 1, 32'h8000_0050); step("stall_mp");
        clr(); pc_write = 0; illop_take = 1; br(32'h8000_0030, 0, 32'h8000_0050, 1, 32'h8000_0050);
        step("illop_mp");
        clr(); irq_take = 1; jmp(32'h8000_0100); step("irq");
        clr(); irq_take = 1; illop_take = 1; step("illop_irq");

        // Aliasing on index 0, then supervisor-bit tag and wraparound
        clr(); br(32'h8000_0000, 1, 32'h8000_0200, 0, 32'h0); step("al_a");
        clr(); jmp(32'h8000_0010); step("j10d");
        clr(); step("al_miss10");
        clr(); br(32'h8000_0010, 1, 32'h8000_0040, 0, 32'h0); step("al_b");
        clr(); jmp(32'h8000_0000); step("j00");
        clr(); step("al_miss0");
        clr(); jmp(32'h0000_0010); step("jsup");
        clr(); step("sup_miss");
        clr(); jmp(32'h8000_0010); step("j10e");
        clr(); step("sup_hit");
        clr(); jmp(32'hFFFF_FFFC); step("jwrap");
        clr(); step("wrap");

        // Valid entry hitting RESET_PC, so reset must clear it
        clr(); br(32'h8000_0000, 1, 32'h8000_0300, 0, 32'h0); step("pre_rst");
        clr(); do_reset("rst2");

        for (int k = 0; k < 10; k++) begin
            clr();
            br(32'h8000_0024, 0, 32'h8000_0060, (k % 3 == 0) && (k < 9), 32'h8000_0060);
            step($sformatf("stat%0d", k));
        end
        chk("stat_br", stat_branches, STATS ? 32'd10 : 32'd0);
        chk("stat_mp", stat_mispred, STATS ? 32'd3 : 32'd0);
        chk("stat_mdl", mb * 100 + mm, 32'd1003);

        clr(); pc_write = 0; jmp(32'h8000_0100); step("stall_pre");
        do_reset("rst_mid");
        clr(); step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
